// File: rtl/reg_sync_if.sv
// reg_sync_if: bundles the read, write, PC and CSPR ports of reg_sync.
interface reg_sync_if;
    logic [3:0]  in_address_1, in_address_2, in_address_3, in_address_4;
    logic        read_enable_1, read_enable_2, read_enable_3, read_enable_4;
    logic [3:0]  write_address_1, write_address_2, write_address_3, write_address_4;
    logic [31:0] write_data_1, write_data_2, write_data_3, write_data_4;
    logic        write_enable_1, write_enable_2, write_enable_3, write_enable_4;
    logic [31:0] pc_update, cspr_update;
    logic        pc_write, cspr_write;
    logic [31:0] out_data_1, out_data_2, out_data_3, out_data_4;
    logic [31:0] pc, cspr;

    modport master (
        output in_address_1, in_address_2, in_address_3, in_address_4,
               read_enable_1, read_enable_2, read_enable_3, read_enable_4,
               write_address_1, write_address_2, write_address_3, write_address_4,
               write_data_1, write_data_2, write_data_3, write_data_4,
               write_enable_1, write_enable_2, write_enable_3, write_enable_4,
               pc_update, pc_write, cspr_update, cspr_write,
        input  out_data_1, out_data_2, out_data_3, out_data_4, pc, cspr
    );

    modport slave (
        input  in_address_1, in_address_2, in_address_3, in_address_4,
               read_enable_1, read_enable_2, read_enable_3, read_enable_4,
               write_address_1, write_address_2, write_address_3, write_address_4,
               write_data_1, write_data_2, write_data_3, write_data_4,
               write_enable_1, write_enable_2, write_enable_3, write_enable_4,
               pc_update, pc_write, cspr_update, cspr_write,
        output out_data_1, out_data_2, out_data_3, out_data_4, pc, cspr
    );
endinterface

// File: rtl/reg_sync.sv
// reg_sync: 16x32 register file with four registered read ports, four write ports, PC and CSPR.
// Reads capture pre-write data; on a write-address collision the highest-numbered port wins.
module reg_sync (
    input logic       clk,
    input logic       rst_n,
    reg_sync_if.slave bus
);
    logic [31:0] regs [16];
    logic [31:0] nxt [16];
    logic [31:0] rd [4];
    logic [31:0] rd_nxt [4];
    logic [31:0] pc_q, cspr_q;
    logic [3:0]  ra [4];
    logic [3:0]  wa [4];
    logic [31:0] wd [4];
    logic [3:0]  re, we;

    assign ra = '{bus.in_address_1, bus.in_address_2, bus.in_address_3, bus.in_address_4};
    assign wa = '{bus.write_address_1, bus.write_address_2, bus.write_address_3, bus.write_address_4};
    assign wd = '{bus.write_data_1, bus.write_data_2, bus.write_data_3, bus.write_data_4};
    assign re = {bus.read_enable_4, bus.read_enable_3, bus.read_enable_2, bus.read_enable_1};
    assign we = {bus.write_enable_4, bus.write_enable_3, bus.write_enable_2, bus.write_enable_1};

    // Ascending port order lets the later assignment, i.e. the higher port, win.
    always_comb begin
        nxt = regs;
        rd_nxt = rd;
        for (int k = 0; k < 4; k++) begin
            if (we[k]) nxt[wa[k]] = wd[k];
            if (re[k]) rd_nxt[k] = regs[ra[k]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs   <= '{default: '0};
            rd     <= '{default: '0};
            pc_q   <= '0;
            cspr_q <= '0;
        end else begin
            regs   <= nxt;
            rd     <= rd_nxt;
            pc_q   <= bus.pc_write ? bus.pc_update : pc_q;
            cspr_q <= bus.cspr_write ? bus.cspr_update : cspr_q;
        end
    end

    assign bus.out_data_1 = rd[0];
    assign bus.out_data_2 = rd[1];
    assign bus.out_data_3 = rd[2];
    assign bus.out_data_4 = rd[3];
    assign bus.pc         = pc_q;
    assign bus.cspr       = cspr_q;
endmodule

// File: tb/tb_reg_sync.sv
// tb_reg_sync: directed vector table, reset corner cases and randomized run against a reference model.
module tb_reg_sync;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    reg_sync_if bus ();
    reg_sync dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Packed arrays: element [0] is port 1, so literals are written {p4,p3,p2,p1}.
    typedef struct {
        logic [3:0]        we;
        logic [3:0][3:0]   wa;
        logic [3:0][31:0]  wd;
        logic [3:0]        re;
        logic [3:0][3:0]   ra;
        logic              pcw;
        logic [31:0]       pcu;
        logic              csw;
        logic [31:0]       csu;
        logic [3:0][31:0]  eo;
        logic [31:0]       epc;
        logic [31:0]       ecs;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [3:0] we, input logic [3:0][3:0] wa,
                                input logic [3:0][31:0] wd, input logic [3:0] re,
                                input logic [3:0][3:0] ra, input logic pcw, input logic [31:0] pcu,
                                input logic csw, input logic [31:0] csu,
                                input logic [3:0][31:0] eo, input logic [31:0] epc,
                                input logic [31:0] ecs);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.pcw = pcw; v.pcu = pcu; v.csw = csw; v.csu = csu;
        v.eo = eo; v.epc = epc; v.ecs = ecs;
        return v;
    endfunction

    task automatic apply(input logic [3:0] we, input logic [3:0][3:0] wa,
                         input logic [3:0][31:0] wd, input logic [3:0] re,
                         input logic [3:0][3:0] ra, input logic pcw, input logic [31:0] pcu,
                         input logic csw, input logic [31:0] csu);
        bus.write_enable_1 = we[0]; bus.write_enable_2 = we[1];
        bus.write_enable_3 = we[2]; bus.write_enable_4 = we[3];
        bus.write_address_1 = wa[0]; bus.write_address_2 = wa[1];
        bus.write_address_3 = wa[2]; bus.write_address_4 = wa[3];
        bus.write_data_1 = wd[0]; bus.write_data_2 = wd[1];
        bus.write_data_3 = wd[2]; bus.write_data_4 = wd[3];
        bus.read_enable_1 = re[0]; bus.read_enable_2 = re[1];
        bus.read_enable_3 = re[2]; bus.read_enable_4 = re[3];
        bus.in_address_1 = ra[0]; bus.in_address_2 = ra[1];
        bus.in_address_3 = ra[2]; bus.in_address_4 = ra[3];
        bus.pc_write = pcw; bus.pc_update = pcu;
        bus.cspr_write = csw; bus.cspr_update = csu;
    endtask

    function automatic logic [31:0] out_of(input int k);
        case (k)
            0: return bus.out_data_1;
            1: return bus.out_data_2;
            2: return bus.out_data_3;
            default: return bus.out_data_4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0][31:0] eo,
                           input logic [31:0] epc, input logic [31:0] ecs);
        for (int k = 0; k < 4; k++) chk($sformatf("%s out_data_%0d", tag, k + 1), out_of(k), eo[k]);
        chk({tag, " pc"}, bus.pc, epc);
        chk({tag, " cspr"}, bus.cspr, ecs);
    endtask

    logic [31:0] m_regs [16];
    logic [31:0] m_out [4];
    logic [31:0] m_pc, m_cs;

    initial begin
        logic [3:0]       we, re;
        logic [3:0][3:0]  wa, ra;
        logic [3:0][31:0] wd, eo;
        logic             pcw, csw;
        logic [31:0]      pcu, csu;

        tbl[0]  = mk(4'b0011, {4'd0, 4'd0, 4'd1, 4'd0}, {32'h0, 32'h0, 32'h1, 32'h2}, 4'b0000, '0,
                     1'b0, '0, 1'b0, '0, '0, '0, '0);
        tbl[1]  = mk(4'b0000, '0, '0, 4'b0011, {4'd0, 4'd0, 4'd1, 4'd0},
                     1'b0, '0, 1'b0, '0, {32'h0, 32'h0, 32'h1, 32'h2}, '0, '0);
        tbl[2]  = mk(4'b1111, {4'd5, 4'd5, 4'd5, 4'd5}, {32'h44, 32'h33, 32'h22, 32'h11}, 4'b0000, '0,
                     1'b0, '0, 1'b0, '0, {32'h0, 32'h0, 32'h1, 32'h2}, '0, '0);
        tbl[3]  = mk(4'b0000, '0, '0, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd5},
                     1'b0, '0, 1'b0, '0, {32'h0, 32'h0, 32'h1, 32'h44}, '0, '0);
        tbl[4]  = mk(4'b0001, {4'd0, 4'd0, 4'd0, 4'd2}, {32'h0, 32'h0, 32'h0, 32'hA}, 4'b0000, '0,
                     1'b0, '0, 1'b0, '0, {32'h0, 32'h0, 32'h1, 32'h44}, '0, '0);
        tbl[5]  = mk(4'b0001, {4'd0, 4'd0, 4'd0, 4'd2}, {32'h0, 32'h0, 32'h0, 32'hB}, 4'b0100,
                     {4'd0, 4'd2, 4'd0, 4'd0}, 1'b0, '0, 1'b0, '0, {32'h0, 32'hA, 32'h1, 32'h44}, '0, '0);
        tbl[6]  = mk(4'b0000, '0, '0, 4'b0100, {4'd0, 4'd2, 4'd0, 4'd0},
                     1'b0, '0, 1'b0, '0, {32'h0, 32'hB, 32'h1, 32'h44}, '0, '0);
        tbl[7]  = mk(4'b0001, {4'd0, 4'd0, 4'd0, 4'd1}, {32'h0, 32'h0, 32'h0, 32'h55}, 4'b0000, '0,
                     1'b0, '0, 1'b0, '0, {32'h0, 32'hB, 32'h1, 32'h44}, '0, '0);
        tbl[8]  = mk(4'b0000, '0, '0, 4'b0010, {4'd0, 4'd0, 4'd1, 4'd0},
                     1'b0, '0, 1'b0, '0, {32'h0, 32'hB, 32'h55, 32'h44}, '0, '0);
        tbl[9]  = mk(4'b0000, '0, '0, 4'b0000, '0, 1'b1, 32'h1000, 1'b1, 32'h8000_0000,
                     {32'h0, 32'hB, 32'h55, 32'h44}, 32'h1000, 32'h8000_0000);
        tbl[10] = mk(4'b0000, '0, '0, 4'b0000, '0, 1'b0, 32'hDEAD, 1'b0, 32'hBEEF,
                     {32'h0, 32'hB, 32'h55, 32'h44}, 32'h1000, 32'h8000_0000);
        tbl[11] = mk(4'b0000, '0, '0, 4'b1000, {4'd5, 4'd0, 4'd0, 4'd0}, 1'b0, '0, 1'b0, '0,
                     {32'h44, 32'hB, 32'h55, 32'h44}, 32'h1000, 32'h8000_0000);
        tbl[12] = mk(4'b0110, {4'd0, 4'd7, 4'd7, 4'd0}, {32'h0, 32'h77, 32'h66, 32'h0}, 4'b0000, '0,
                     1'b0, '0, 1'b0, '0, {32'h44, 32'hB, 32'h55, 32'h44}, 32'h1000, 32'h8000_0000);
        tbl[13] = mk(4'b0000, '0, '0, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd7}, 1'b0, '0, 1'b0, '0,
                     {32'h44, 32'hB, 32'h55, 32'h77}, 32'h1000, 32'h8000_0000);

        apply('0, '0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1 chk_all("reset", '0, '0, '0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra,
                  tbl[i].pcw, tbl[i].pcu, tbl[i].csw, tbl[i].csu);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), tbl[i].eo, tbl[i].epc, tbl[i].ecs);
        end

        // Fill every register with nonzero data, then make all outputs nonzero.
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                wa[k] = 4'(c * 4 + k);
                wd[k] = 32'hA000_0000 + 32'(c * 4 + k + 1);
            end
            @(negedge clk) apply(4'b1111, wa, wd, '0, '0, 1'b0, '0, 1'b0, '0);
        end
        @(negedge clk) apply('0, '0, '0, 4'b1111, {4'd15, 4'd14, 4'd13, 4'd12}, 1'b1, 32'h4444, 1'b1, 32'h5555);
        @(posedge clk);
        #1 chk("prefill out_data_4", bus.out_data_4, 32'hA000_0010);

        // Reset between edges with a write pending: must clear immediately and discard the write.
        @(negedge clk) apply(4'b1111, {4'd3, 4'd2, 4'd1, 4'd0}, {4{32'hFFFF_FFFF}}, 4'b1111,
                             {4'd15, 4'd14, 4'd13, 4'd12}, 1'b1, 32'h7777, 1'b1, 32'h8888);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_async", '0, '0, '0);
        @(posedge clk);
        #1 chk_all("rst_held", '0, '0, '0);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) ra[k] = 4'(c * 4 + k);
            if (c == 0) apply('0, '0, '0, 4'b1111, ra, 1'b0, '0, 1'b0, '0);
            else begin
                @(negedge clk);
                apply('0, '0, '0, 4'b1111, ra, 1'b0, '0, 1'b0, '0);
            end
            @(posedge clk);
            #1 chk_all($sformatf("post_rst%0d", c), '0, '0, '0);
        end

        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        for (int k = 0; k < 4; k++) m_out[k] = '0;
        m_pc = '0;
        m_cs = '0;
        for (int n = 0; n < 300; n++) begin
            we  = 4'($urandom);
            re  = 4'($urandom);
            pcw = 1'($urandom);
            csw = 1'($urandom);
            pcu = $urandom;
            csu = $urandom;
            for (int k = 0; k < 4; k++) begin
                wa[k] = 4'($urandom_range(0, 15));
                ra[k] = 4'($urandom_range(0, 15));
                wd[k] = $urandom;
            end
            @(negedge clk) apply(we, wa, wd, re, ra, pcw, pcu, csw, csu);
            for (int k = 0; k < 4; k++) if (re[k]) m_out[k] = m_regs[ra[k]];
            for (int k = 0; k < 4; k++) if (we[k]) m_regs[wa[k]] = wd[k];
            if (pcw) m_pc = pcu;
            if (csw) m_cs = csu;
            for (int k = 0; k < 4; k++) eo[k] = m_out[k];
            @(posedge clk);
            #1 chk_all($sformatf("rand%0d", n), eo, m_pc, m_cs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
